mult_unit: RTL and testbench



---
 rtl/mult_unit_pkg.sv | 24 ++
 rtl/mult_unit_ks_add.sv | 56 +++++
 rtl/mult_unit.sv | 148 ++++++++++++++
 tb/tb_mult_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_unit_pkg.sv
// ---------------------------------------------------------------------------
// mult_unit_pkg
//   Shared definitions for the EX-stage multiplier:
//     mul_state_e   - controller state encoding (IDLE / RUN / FIX)
//     MUL_ITER      - number of shift-add iterations (one per multiplier bit)
//     MUL_CNT_W     - width of the iteration counter
//     MUL_CNT_LAST  - counter value of the final RUN iteration
//     MUL_CNT_ONE   - counter increment, sized to the counter
// ---------------------------------------------------------------------------
package mult_unit_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_FIX  = 2'd2
    } mul_state_e;

    localparam int unsigned MUL_ITER  = 32;
    localparam int unsigned MUL_CNT_W = 5;

    localparam logic [MUL_CNT_W-1:0] MUL_CNT_LAST = MUL_CNT_W'(MUL_ITER - 1);
    localparam logic [MUL_CNT_W-1:0] MUL_CNT_ONE  = MUL_CNT_W'(1);

endpackage : mult_unit_pkg

// File: rtl/mult_unit_ks_add.sv
// ---------------------------------------------------------------------------
// mult_unit_ks_add
//   Combinational Kogge-Stone adder (KS_ADD), the same structure the ALU uses.
//   The multiplier drives it once per RUN iteration with the partial-product
//   accumulator and the (gated) multiplicand.
//
//   Ports:
//     a_i, b_i  in  WIDTH  addends
//     cin_i     in  1      carry in
//     sum_o     out WIDTH  a_i + b_i + cin_i (low WIDTH bits)
//     cout_o    out 1      carry out of the most significant bit
// ---------------------------------------------------------------------------
module mult_unit_ks_add #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int unsigned LVL = $clog2(WIDTH);

    logic [WIDTH-1:0] hs;     // half sum
    logic [WIDTH-1:0] grp_g;  // group generate, from bit 0 after the last level
    logic [WIDTH-1:0] grp_p;  // group propagate
    logic [WIDTH:0]   carry;

    always_comb begin
        hs    = a_i ^ b_i;
        grp_g = a_i & b_i;
        grp_p = hs;
        // Folding cin into bit 0 makes the final group generate equal to
        // the carry out of each bit position.
        grp_g[0] = (a_i[0] & b_i[0]) | (hs[0] & cin_i);

        // Prefix levels with span 1, 2, 4, ... Bits are updated from the top
        // down, so each bit reads its lower partner before that partner is
        // overwritten; this is the parallel Kogge-Stone network written
        // in place.
        for (int unsigned k = 0; k < LVL; k++) begin
            for (int unsigned j = 0; j < WIDTH - (32'd1 << k); j++) begin
                grp_g[WIDTH-1-j] = grp_g[WIDTH-1-j]
                                 | (grp_p[WIDTH-1-j] & grp_g[WIDTH-1-j-(32'd1 << k)]);
                grp_p[WIDTH-1-j] = grp_p[WIDTH-1-j] & grp_p[WIDTH-1-j-(32'd1 << k)];
            end
        end

        carry[0]       = cin_i;
        carry[WIDTH:1] = grp_g;
        sum_o          = hs ^ carry[WIDTH-1:0];
        cout_o         = carry[WIDTH];
    end

endmodule : mult_unit_ks_add

// File: rtl/mult_unit.sv
// ---------------------------------------------------------------------------
// mult_unit
//   Multi-cycle 32x32->64 multiplier for MULT/MULTU with the architectural
//   HI/LO registers and MTHI/MTLO writes. Radix-2 shift-add: one KS_ADD pass
//   per multiplier bit on operand magnitudes, followed by a sign fix-up.
//   Start-to-done latency is 34 cycles; the pipeline stalls on busy.
//
//   Ports:
//     clk        in  1      clock, rising edge
//     reset      in  1      synchronous, active-high
//     start      in  1      launch a multiply (accepted only in IDLE)
//     is_signed  in  1      1 = MULT, 0 = MULTU (sampled with start)
//     op_a       in  WIDTH  multiplicand (sampled with start)
//     op_b       in  WIDTH  multiplier   (sampled with start)
//     hi_we      in  1      MTHI strobe (IDLE only, dropped if start)
//     lo_we      in  1      MTLO strobe (IDLE only, dropped if start)
//     wdata      in  WIDTH  MTHI/MTLO data
//     busy       out 1      multiply in progress
//     done       out 1      one-cycle pulse; hi/lo hold the new product
//     hi, lo     out WIDTH  architectural HI/LO
// ---------------------------------------------------------------------------
module mult_unit
    import mult_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned PW = 2 * WIDTH;

    mul_state_e           state_q;
    logic [WIDTH-1:0]     acc_hi_q;
    logic [WIDTH-1:0]     acc_lo_q;
    logic [WIDTH-1:0]     mcand_q;
    logic                 neg_q;
    logic [MUL_CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0]     mag_a_d;
    logic [WIDTH-1:0]     mag_b_d;
    logic                 neg_d;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     ks_sum;
    logic                 ks_cout;
    logic [PW-1:0]        prod_raw;
    logic [PW-1:0]        prod_fix_d;

    // Operand magnitudes. 0x80000000 negates to itself and is then used as
    // an unsigned magnitude, which keeps the result correct.
    always_comb begin
        mag_a_d = (is_signed && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
        mag_b_d = (is_signed && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;
        neg_d   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
    end

    // Current multiplier bit gates the multiplicand into the adder.
    always_comb begin
        addend = acc_lo_q[0] ? mcand_q : '0;
    end

    mult_unit_ks_add #(
        .WIDTH (WIDTH)
    ) u_ks_add (
        .a_i    (acc_hi_q),
        .b_i    (addend),
        .cin_i  (1'b0),
        .sum_o  (ks_sum),
        .cout_o (ks_cout)
    );

    // Sign fix-up of the unsigned magnitude product.
    always_comb begin
        prod_raw   = {acc_hi_q, acc_lo_q};
        prod_fix_d = neg_q ? (~prod_raw + PW'(1)) : prod_raw;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MUL_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                MUL_IDLE: begin
                    if (start) begin
                        neg_q    <= neg_d;
                        mcand_q  <= mag_a_d;
                        acc_lo_q <= mag_b_d;
                        acc_hi_q <= '0;
                        cnt_q    <= '0;
                        busy     <= 1'b1;
                        state_q  <= MUL_RUN;
                    end else begin
                        if (hi_we) begin
                            hi <= wdata;
                        end
                        if (lo_we) begin
                            lo <= wdata;
                        end
                    end
                end

                MUL_RUN: begin
                    // 33-bit sum shifted right by one; the consumed
                    // multiplier bit falls off the bottom of acc_lo.
                    {acc_hi_q, acc_lo_q} <= {ks_cout, ks_sum, acc_lo_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + MUL_CNT_ONE;
                    if (cnt_q == MUL_CNT_LAST) begin
                        state_q <= MUL_FIX;
                    end
                end

                MUL_FIX: begin
                    {hi, lo} <= prod_fix_d;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state_q  <= MUL_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    state_q <= MUL_IDLE;
                end
            endcase
        end
    end

endmodule : mult_unit

// File: tb/tb_mult_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_unit
//   Scoreboard bench for mult_unit: expected products are queued when a
//   multiply is launched and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_mult_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    mult_unit #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    int unsigned n_vec     = 0;
    int unsigned n_err     = 0;
    int unsigned done_seen = 0;
    logic [63:0] sb_q[$];
    logic [63:0] mon_exp;
    string       cur_tag   = "init";

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        if (sgn) begin
            sa  = {{32{a[31]}}, a};
            sbv = {{32{b[31]}}, b};
            return sa * sbv;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Result monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (!reset && done) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                chk({cur_tag, ".unexpected_done"}, {63'd0, done}, 64'd0);
            end else begin
                mon_exp = sb_q.pop_front();
                chk({cur_tag, ".hi"}, {32'd0, hi}, {32'd0, mon_exp[63:32]});
                chk({cur_tag, ".lo"}, {32'd0, lo}, {32'd0, mon_exp[31:0]});
            end
        end
    end

    // Launches a multiply from the current (negedge) time and returns at the
    // negedge of the done cycle, so a following call is back-to-back.
    task automatic do_mul(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input bit we_at_start, input bit disturb);
        int unsigned bcnt;
        int unsigned lat;
        logic [31:0] hi_hold;
        logic [31:0] lo_hold;
        hi_hold   = hi;
        lo_hold   = lo;
        cur_tag   = tag;
        start     = 1'b1;
        is_signed = sgn;
        op_a      = a;
        op_b      = b;
        hi_we     = we_at_start;
        lo_we     = we_at_start;
        wdata     = 32'hDEAD_BEEF;
        sb_q.push_back(model(sgn, a, b));
        @(posedge clk);
        #1;
        start     = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        is_signed = 1'($urandom);
        op_a      = $urandom;
        op_b      = $urandom;
        chk({tag, ".hi_at_start"}, {32'd0, hi}, {32'd0, hi_hold});
        bcnt = 0;
        lat  = 0;
        for (int unsigned n = 1; n <= 60 && lat == 0; n++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = n;
            end else if (disturb && n == 5) begin
                start = 1'b1;
                op_a  = 32'h0000_0100;
                op_b  = 32'h0000_0100;
                hi_we = 1'b1;
                lo_we = 1'b1;
                wdata = 32'h1234_5678;
            end else if (disturb && n == 6) begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
                chk({tag, ".hi_run"}, {32'd0, hi}, {32'd0, hi_hold});
                chk({tag, ".lo_run"}, {32'd0, lo}, {32'd0, lo_hold});
            end
        end
        chk({tag, ".latency"}, 64'(lat), 64'd34);
        chk({tag, ".busy_cycles"}, 64'(bcnt), 64'd33);
    endtask

    task automatic idle(input int unsigned k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned d0;
        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        op_a      = '0;
        op_b      = '0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        wdata     = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset.busy", {63'd0, busy}, 64'd0);
        chk("reset.done", {63'd0, done}, 64'd0);
        chk("reset.hi", {32'd0, hi}, 64'd0);
        chk("reset.lo", {32'd0, lo}, 64'd0);

        do_mul("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(2);
        do_mul("mult_m1x1", 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        idle(1);
        do_mul("mult_minmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        idle(1);
        do_mul("mult_7xm3", 1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 1'b0);
        idle(1);
        do_mul("multu_zero", 1'b0, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0);
        idle(1);

        // MTHI / MTLO in IDLE
        cur_tag = "mthi_mtlo";
        hi_we = 1'b1;
        wdata = 32'hAAAA_0000;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b1;
        wdata = 32'h0000_5555;
        chk("mthi.hi", {32'd0, hi}, 64'h0000_0000_AAAA_0000);
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo.lo", {32'd0, lo}, 64'h0000_0000_0000_5555);
        chk("mtlo.hi_kept", {32'd0, hi}, 64'h0000_0000_AAAA_0000);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0F0F_3C3C;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk("mt_both.hi", {32'd0, hi}, 64'h0000_0000_0F0F_3C3C);
        chk("mt_both.lo", {32'd0, lo}, 64'h0000_0000_0F0F_3C3C);

        // start beats a same-cycle write; writes and start ignored while busy
        do_mul("start_vs_we", 1'b0, 32'd2, 32'd3, 1'b1, 1'b1);
        idle(3);

        for (int unsigned i = 0; i < 5; i++) begin
            do_mul($sformatf("rand%0d", i), 1'($urandom), $urandom, $urandom, 1'b0, 1'b0);
            idle(1);
        end
        do_mul("pre_reset", 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        idle(1);

        // Abort with reset in cycle 10 of a MULTU
        cur_tag   = "abort";
        d0        = done_seen;
        start     = 1'b1;
        is_signed = 1'b0;
        op_a      = 32'hFFFF_FFFF;
        op_b      = 32'h1234_5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort.busy", {63'd0, busy}, 64'd0);
        chk("abort.hi", {32'd0, hi}, 64'd0);
        chk("abort.lo", {32'd0, lo}, 64'd0);
        idle(30);
        chk("abort.no_done", 64'(done_seen - d0), 64'd0);
        do_mul("after_abort", 1'b0, 32'd3, 32'd5, 1'b0, 1'b0);

        // Back-to-back: second start issued in the done cycle
        idle(2);
        do_mul("b2b_first", 1'b1, 32'h7FFF_FFFF, 32'h8000_0001, 1'b0, 1'b0);
        do_mul("b2b_second", 1'b0, 32'hCAFE_BABE, 32'h1357_9BDF, 1'b0, 1'b0);
        idle(3);

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mult_unit
